// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard_pkg: shared constants and types for the decode-stage register scoreboard.
package regfile_scoreboard_pkg;
    localparam int NUM_REGS       = 8;
    localparam int REG_IDX_W      = 3;
    localparam int WB_LAT_DEFAULT = 3;
    localparam int CNT_W          = 3;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0]     sb_cnt_t;
endpackage

// File: rtl/regfile_scoreboard_sb_entry.sv
// sb_entry: per-register write-back countdown with busy and hazard flags.
// SCOREBOARD_FWD_EN: regFile bypasses write-before-read, so the final countdown cycle is no hazard.
module sb_entry
    import regfile_scoreboard_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  sb_cnt_t load_val,
    output sb_cnt_t cnt,
    output logic    busy,
    output logic    hz
);
    sb_cnt_t cnt_q, cnt_d;
    logic    busy_q;
    always_comb cnt_d = load ? load_val : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end
    assign cnt  = cnt_q;
    assign busy = busy_q;
`ifdef SCOREBOARD_FWD_EN
    assign hz = (cnt_q > sb_cnt_t'(1));
`else
    assign hz = (cnt_q != '0);
`endif
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: RAW hazard stall control for decode, with saturating stall statistics.
// Build with SCOREBOARD_FWD_EN to assume write-before-read bypass in the regFile.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int WB_LAT = WB_LAT_DEFAULT,
    parameter int STAT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  reg_idx_t            rs_sel,
    input  logic                rs_used,
    input  reg_idx_t            rt_sel,
    input  logic                rt_used,
    input  reg_idx_t            rd_sel,
    input  logic                rd_wr,
    input  logic                flush,
    output logic                stall,
    output logic                issue,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [STAT_W-1:0]   stall_cnt
);
    logic [NUM_REGS-1:0] hz, load;
    sb_cnt_t             unused_cnt [NUM_REGS];
    logic [STAT_W-1:0]   stall_cnt_q, stall_cnt_d;
    // hazard check uses pre-load state, so an instruction never stalls on its own write
    assign stall = ~rst & id_valid & ~flush & ((rs_used & hz[rs_sel]) | (rt_used & hz[rt_sel]));
    assign issue = ~rst & id_valid & ~flush & ~stall;
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
        assign load[i] = issue & rd_wr & (rd_sel == reg_idx_t'(i));
        sb_entry u_entry (
            .clk      (clk),
            .rst      (rst),
            .load     (load[i]),
            .load_val (sb_cnt_t'(WB_LAT)),
            .cnt      (unused_cnt[i]),
            .busy     (busy_vec[i]),
            .hz       (hz[i])
        );
    end
    always_comb stall_cnt_d = (stall & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end
    assign stall_cnt = stall_cnt_q;
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Pipelined-core hazard controller for the decode-stage register file.
- Tracks in-flight writes to the 8 architectural registers with a per-register countdown.
- Asserts stall to hold IF/ID while a decoding instruction reads a register whose write has not yet landed.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- NUM_REGS, 8, number of architectural registers; index width is clog2(NUM_REGS) = 3.
- WB_LAT, 3, cycles from decode issue until the regFile write is committed; range 1 to 7.
- CNT_W, 3, countdown width; must satisfy 2^CNT_W > WB_LAT.
- STAT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  a valid instruction is in decode.
- rs_sel  in  3  instr[10:8] source register.
- rs_used  in  1  instruction reads RS.
- rt_sel  in  3  second source register (RT).
- rt_used  in  1  instruction reads RT.
- rd_sel  in  3  destination register after RegDst mux (instr[7:5], [10:8], [4:2] or 7).
- rd_wr  in  1  RegWrt control for the decoding instruction.
- flush  in  1  branch/jump redirect; kills the instruction in decode.
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- issue  out  1  decode instruction advances this cycle.
- busy_vec  out  NUM_REGS  bit i set while register i has a pending write.
- stall_cnt  out  STAT_W  saturating count of stalled cycles.

Behaviour:
- Reset: one clock (clk) and one asynchronous active-high reset (rst). While rst is high, all countdowns, busy_vec, stall_cnt, stall and issue are 0 immediately, without waiting for a clock edge.
- busy[i] = (cnt[i] != 0). busy_vec is registered state, not combinational.
- stall = id_valid & ~flush & ((rs_used & hz[rs_sel]) | (rt_used & hz[rt_sel])), where the hazard term hz is defined under Optional Feature. stall is combinational from the inputs and current state.
- issue = id_valid & ~flush & ~stall.
- Per-register counter update on each clk edge, highest priority first:
  1. If issue & rd_wr & (rd_sel == i), cnt[i] <= WB_LAT. This load also covers the WAW case: a newer write reloads the counter even if it is mid-count.
  2. Else if cnt[i] != 0, cnt[i] <= cnt[i] - 1.
  3. Else hold at 0.
- Load coincident with a counter reaching zero: the load wins.
- Load to register X while another register's counter expires: each register updates independently.
- RS == RT == RD (e.g. ADD r3,r3,r3): the stall check uses pre-load state, so the instruction never stalls on its own write.
- flush suppresses both issue and load for the killed instruction. Existing counters keep counting; older instructions still write back, so this is conservative and correct.
- stall_cnt increments by 1 on every edge where stall = 1 and saturates at all-ones without wrapping.
- No register is hardwired to zero; R7 (link) is tracked like any other register.
- Reset asserted mid-countdown clears everything; the first post-reset instruction never stalls.
- Latency: decode-to-visible-write equals WB_LAT cycles.

Optional Feature:
- Macro: SCOREBOARD_FWD_EN.
- Defined: the regFile uses write-before-read bypass, so hz[i] = (cnt[i] > 1). A consumer may issue in the cycle the write lands, saving one stall cycle per RAW hazard.
- Undefined: hz[i] = (cnt[i] != 0), with no bypass assumed.
- busy_vec semantics are identical in both builds.

Decomposition:
- Shared package:
  - constants NUM_REGS, REG_IDX_W = 3, WB_LAT_DEFAULT = 3.
  - typedef reg_idx_t (3-bit).
  - typedef sb_cnt_t (CNT_W-bit).
- Sub-module sb_entry: one per register, generated NUM_REGS times.
  - Inputs: clk, rst, load, load_val.
  - Outputs: cnt, busy, hz.
  - Implements the load/decrement/hold priority above.
- The top level contains the hazard OR-reduce, issue logic and stall_cnt.

Test Plan (WB_LAT=3; the instruction issues in cycle 0):
- Reset: assert rst asynchronously between edges → busy_vec=8'h00, stall=0 and stall_cnt=0 immediately; all stay 0 after release.
- RAW: cycle 0 issues rd=3, rd_wr=1; cycle 1 presents rs_sel=3, rs_used=1.
  - Without FWD: stall=1 in cycles 1–3, issue in cycle 4, stall_cnt=3.
  - With FWD: stall in cycles 1–2, issue in cycle 3, stall_cnt=2.
- WAW: rd=5 issued in cycle 0 and again in cycle 2 → busy_vec[5] stays 1 through cycle 5 and clears in cycle 6; a cycle-3 read of r5 stalls until cycle 6.
- Unused operand: r2 busy, rt_sel=2, rt_used=0, rs unrelated → stall=0, issue=1.
- Flush: id_valid=1, rd_wr=1, rd_sel=4, flush=1 → issue=0, stall=0, busy_vec[4] stays 0 next cycle. Concurrently pending r1 continues counting down.
- Saturation: force a 70000-cycle stall with STAT_W=16 → stall_cnt holds at 16'hFFFF without wrapping.
